cond_issue_ctrl: RTL

Condition-check issue controller between decode and execute. Owns the architectural CPSR register, evaluates each incoming instruction's condition field against it, and marks the instruction execute or squash. It tracks in-flight flag-setting instructions and stalls conditional instructions until their flags have been written back. It also merges ALU flag writebacks and MSR writes into the CPSR.

---
 rtl/cond_issue_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cond_issue_ctrl.sv
// Condition-check issue controller sitting between decode and execute.
// Holds the architectural CPSR, evaluates each instruction's condition
// field against it, and presents the instruction to execute marked as
// execute or squash. Conditional instructions wait while flag-setting
// instructions are still in flight, so they always see the final flags.
module cond_issue_ctrl #(
    parameter int unsigned MAX_PENDING = 3,
    parameter logic [31:0] CPSR_RESET  = 32'h0000_00D3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic        in_sets_flags,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic        out_exec,
    input  logic        out_ready,
    input  logic        flag_wr_en,
    input  logic [3:0]  flag_wr_nzcv,
    input  logic        msr_wr_en,
    input  logic [31:0] msr_data,
    input  logic        flush,
    output logic [31:0] cpsr,
    output logic [2:0]  pending
);

    localparam logic [2:0] MAX_PEND = 3'(MAX_PENDING);
    localparam logic [3:0] COND_AL  = 4'b1110;

    // Output buffer occupancy; the state alone is out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic        exec_q, exec_d;
    logic [31:0] cpsr_q, cpsr_d;
    logic [2:0]  pending_q, pending_d;

    logic [3:0]  cond;
    logic        cond_pass;
    logic        hazard;
    logic        full_block;
    logic        accept;
    logic        consume;
    logic        pend_inc;
    logic        pend_dec;

    // Evaluate the condition field against the registered CPSR only; a flag
    // write in this cycle becomes visible to evaluation next cycle.
    always_comb begin
        logic n, z, c, v;
        n = cpsr_q[31];
        z = cpsr_q[30];
        c = cpsr_q[29];
        v = cpsr_q[28];
        cond = in_inst[31:28];
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Handshake: conditional instructions wait on in-flight flag setters,
    // and an executing flag setter waits when the tracker is full.
    assign hazard     = (cond != COND_AL) && (pending_q != 3'd0);
    assign full_block = in_sets_flags && cond_pass && (pending_q == MAX_PEND);
    assign in_ready   = !reset && (!out_valid || out_ready) && !flush
                        && !hazard && !full_block;
    assign accept     = in_valid && in_ready;
    assign consume    = out_valid && out_ready;
    assign pend_inc   = accept && cond_pass && in_sets_flags;
    assign pend_dec   = flag_wr_en;

    // Output buffer next state: load on accept, drain on consume or flush.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        exec_d  = exec_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    inst_d  = in_inst;
                    exec_d  = cond_pass;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    inst_d  = in_inst;
                    exec_d  = cond_pass;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // In-flight flag-setter count; simultaneous inc/dec cancel, dec saturates.
    always_comb begin
        pending_d = pending_q;
        if (pend_inc && !pend_dec) begin
            pending_d = pending_q + 3'd1;
        end else if (pend_dec && !pend_inc && (pending_q != 3'd0)) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // CPSR merge: MSR loads the whole word, an ALU flag write then overrides NZCV.
    always_comb begin
        cpsr_d = cpsr_q;
        if (msr_wr_en) begin
            cpsr_d = msr_data;
        end
        if (flag_wr_en) begin
            cpsr_d[31:28] = flag_wr_nzcv;
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            inst_q    <= 32'd0;
            exec_q    <= 1'b0;
            cpsr_q    <= CPSR_RESET;
            pending_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            exec_q    <= exec_d;
            cpsr_q    <= cpsr_d;
            pending_q <= pending_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_inst  = inst_q;
    assign out_exec  = exec_q;
    assign cpsr      = cpsr_q;
    assign pending   = pending_q;

endmodule
